// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory
// responder (slave).
interface data_memory_responder_if;
   logic        request_valid;
   logic        request_ready;
   logic        request_write;
   logic [31:0] request_address;
   logic [31:0] request_write_data;
   logic [3:0]  request_byte_enable;
   logic        response_valid;
   logic [31:0] response_read_data;
   logic        response_error;

   modport master (
      output request_valid, request_write, request_address,
             request_write_data, request_byte_enable,
      input  request_ready, response_valid, response_read_data, response_error
   );

   modport slave (
      input  request_valid, request_write, request_address,
             request_write_data, request_byte_enable,
      output request_ready, response_valid, response_read_data, response_error
   );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency word memory behind a valid/ready request port with a
// one-cycle response pulse; misaligned or out-of-range requests report an error.
module data_memory_responder #(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input logic                    system_clock,
   input logic                    reset,
   data_memory_responder_if.slave bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

   state_t           state, state_next;
   logic [3:0]       count, count_next;
   logic             accept;
   logic             access;
   logic             wr_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic [31:0]      resp_data;
   logic             resp_err;
   logic             err;
   logic [IDX_W-1:0] idx;
   logic [31:0]      mem [DEPTH_WORDS];

   assign bus.request_ready = !reset && (state != BUSY);
   assign accept            = bus.request_valid && bus.request_ready;

   assign err = (addr_q[1:0] != 2'b00) ||
                ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign idx = addr_q[IDX_W+1:2];

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      count_next = count;
      access     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = BUSY;
               count_next = 4'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (count != 4'd0) begin
               count_next = count - 4'd1;
            end else begin
               access     = 1'b1;
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            if (accept) begin
               state_next = BUSY;
               count_next = 4'(LATENCY - 1);
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= 4'd0;
         wr_q      <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         be_q      <= 4'd0;
         resp_data <= 32'd0;
         resp_err  <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (accept) begin
            wr_q    <= bus.request_write;
            addr_q  <= bus.request_address;
            wdata_q <= bus.request_write_data;
            be_q    <= bus.request_byte_enable;
         end
         if (access) begin
            resp_err  <= err;
            resp_data <= (err || wr_q) ? 32'd0 : mem[idx];
         end
      end
   end

   // NOTE: the storage array is deliberately left out of reset so contents survive it.
   always_ff @(posedge system_clock) begin
      if (access && wr_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   // Response fields read as zero outside the pulse.
   assign bus.response_valid     = (state == RESPOND);
   assign bus.response_read_data = (state == RESPOND) ? resp_data : 32'd0;
   assign bus.response_error     = (state == RESPOND) ? resp_err  : 1'b0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=2 instance driven from a
// vector table plus corner sequences, and a LATENCY=1 instance.
module tb_data_memory_responder;

   logic system_clock = 1'b0;
   logic reset        = 1'b1;
   int   tests        = 0;
   int   fails        = 0;

   always #5 system_clock = ~system_clock;

   data_memory_responder_if bus2();
   data_memory_responder_if bus1();

   data_memory_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut2 (
      .system_clock (system_clock),
      .reset        (reset),
      .bus          (bus2.slave)
   );

   data_memory_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut1 (
      .system_clock (system_clock),
      .reset        (reset),
      .bus          (bus1.slave)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One request on the LATENCY=2 instance, checking latency, payload and pulse width.
   task automatic transact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_data, input logic exp_err);
      int lat;
      lat = 0;
      @(negedge system_clock);
      bus2.request_valid       = 1'b1;
      bus2.request_write       = wr;
      bus2.request_address     = addr;
      bus2.request_write_data  = wdata;
      bus2.request_byte_enable = be;
      check("ready_before_accept", 32'(bus2.request_ready), 32'd1);
      @(posedge system_clock);
      #1 bus2.request_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge system_clock);
         #1;
         if (bus2.response_valid) begin
            lat = n;
            break;
         end
         check("busy_ready_low", 32'(bus2.request_ready), 32'd0);
      end
      check("latency", 32'(lat), 32'd2);
      check("resp_data", bus2.response_read_data, exp_data);
      check("resp_err", 32'(bus2.response_error), 32'(exp_err));
      check("respond_ready", 32'(bus2.request_ready), 32'd1);
      @(posedge system_clock);
      #1;
      check("pulse_end", {bus2.response_valid, bus2.response_error, bus2.response_read_data[29:0]},
            32'd0);
   endtask

   // One request on the LATENCY=1 instance.
   task automatic transact1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data);
      @(negedge system_clock);
      bus1.request_valid       = 1'b1;
      bus1.request_write       = wr;
      bus1.request_address     = addr;
      bus1.request_write_data  = wdata;
      bus1.request_byte_enable = 4'hF;
      @(posedge system_clock);
      #1 bus1.request_valid = 1'b0;
      check("l1_busy_valid", 32'(bus1.response_valid), 32'd0);
      check("l1_busy_ready", 32'(bus1.request_ready), 32'd0);
      @(posedge system_clock);
      #1;
      check("l1_valid", 32'(bus1.response_valid), 32'd1);
      check("l1_respond_ready", 32'(bus1.request_ready), 32'd1);
      check("l1_data", bus1.response_read_data, exp_data);
      @(posedge system_clock);
      #1;
      check("l1_pulse_end", 32'(bus1.response_valid), 32'd0);
   endtask

   initial begin
      int acc, last_acc, pulses, stray;
      logic r, rv, prev_rv;
      logic [31:0] b2b_addr [3];
      logic [31:0] b2b_exp  [3];

      vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[6]  = '{1'b0, 32'h6,    32'h0,        4'h0, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[9]  = '{1'b1, 32'h24,   32'h01020304, 4'hF, 32'h0,        1'b0};
      vecs[10] = '{1'b1, 32'h24,   32'h55555555, 4'h0, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 32'h24,   32'h0,        4'h0, 32'h01020304, 1'b0};
      vecs[12] = '{1'b1, 32'hFFC,  32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h0BADC0DE, 1'b0};
      vecs[14] = '{1'b1, 32'hFFD,  32'h12121212, 4'hF, 32'h0,        1'b1};

      bus2.request_valid = 1'b0; bus2.request_write = 1'b0; bus2.request_address = '0;
      bus2.request_write_data = '0; bus2.request_byte_enable = '0;
      bus1.request_valid = 1'b0; bus1.request_write = 1'b0; bus1.request_address = '0;
      bus1.request_write_data = '0; bus1.request_byte_enable = '0;

      // Reset state
      repeat (2) @(negedge system_clock);
      bus2.request_valid = 1'b1;
      #1;
      check("rst_ready", 32'(bus2.request_ready), 32'd0);
      check("rst_valid", 32'(bus2.response_valid), 32'd0);
      check("rst_data", bus2.response_read_data, 32'd0);
      check("rst_err", 32'(bus2.response_error), 32'd0);
      bus2.request_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("ready_after_reset", 32'(bus2.request_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         transact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                  vecs[i].exp_data, vecs[i].exp_err);
      end

      // Back-to-back loads with request_valid held high
      b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hDEADBEEF;
      b2b_addr[1] = 32'h20; b2b_exp[1] = 32'h11BB33DD;
      b2b_addr[2] = 32'h0;  b2b_exp[2] = 32'hCAFEF00D;
      acc = 0; last_acc = -1; pulses = 0; prev_rv = 1'b0;
      @(negedge system_clock);
      bus2.request_valid   = 1'b1;
      bus2.request_write   = 1'b0;
      bus2.request_address = b2b_addr[0];
      for (int c = 0; c < 14; c++) begin
         r  = bus2.request_ready;
         rv = bus2.response_valid;
         if (rv) begin
            if (pulses < 3) check("b2b_data", bus2.response_read_data, b2b_exp[pulses]);
            pulses++;
            check("b2b_single_pulse", 32'(prev_rv), 32'd0);
         end
         prev_rv = rv;
         if (r && bus2.request_valid) begin
            if (last_acc >= 0) check("b2b_spacing", 32'(c - last_acc), 32'd3);
            last_acc = c;
         end
         @(posedge system_clock);
         #1;
         if (r && bus2.request_valid) begin
            acc++;
            if (acc == 3) bus2.request_valid = 1'b0;
            else bus2.request_address = b2b_addr[acc];
         end
         @(negedge system_clock);
      end
      check("b2b_accepts", 32'(acc), 32'd3);
      check("b2b_pulses", 32'(pulses), 32'd3);

      // Reset while BUSY aborts the store
      transact(1'b1, 32'h40, 32'h0F0F0F0F, 4'hF, 32'h0, 1'b0);
      @(negedge system_clock);
      bus2.request_valid      = 1'b1;
      bus2.request_write      = 1'b1;
      bus2.request_address    = 32'h40;
      bus2.request_write_data = 32'h12345678;
      bus2.request_byte_enable = 4'hF;
      @(posedge system_clock);
      #1 bus2.request_valid = 1'b0;
      @(negedge system_clock);
      reset = 1'b1;
      @(negedge system_clock);
      reset = 1'b0;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge system_clock);
         #1;
         if (bus2.response_valid) stray++;
      end
      check("abort_no_response", 32'(stray), 32'd0);
      transact(1'b0, 32'h40, 32'h0, 4'h0, 32'h0F0F0F0F, 1'b0);

      // LATENCY=1 instance
      transact1(1'b1, 32'h8, 32'h76543210, 32'h0);
      transact1(1'b0, 32'h8, 32'h0, 32'h76543210);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
